hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush, memory-wait freeze, operand forwarding.
// Latency: stall/flush outputs are combinational (same cycle); fwdA_X/fwdB_X are registered (1 cycle).
// Backpressure: a pending data-memory access (mem_req_M & ~mem_ready) freezes the whole pipe front.
//
// Ports:
//   clk, rst (async active-low)
//   rs_D/rt_D, use_rs_D/use_rt_D      : Decode sources
//   dst_X/dst_M, RegWrite_X/M, MemRead_X : Execute/Memory producers
//   mem_req_M, mem_ready              : data-memory handshake
//   BeqValid_X, Jump_D                : control-flow redirects
//   stall_FD, stall_XM, flush_D/X/W   : pipeline register controls
//   fwdA_X, fwdB_X                    : 00 regfile, 01 from M, 10 from W
//   mem_timeout (sticky), stall_cnt (saturating)
module hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic             use_rs_D,
    input  logic             use_rt_D,
    input  logic [4:0]       dst_X,
    input  logic [4:0]       dst_M,
    input  logic             RegWrite_X,
    input  logic             RegWrite_M,
    input  logic             MemRead_X,
    input  logic             mem_req_M,
    input  logic             mem_ready,
    input  logic             BeqValid_X,
    input  logic             Jump_D,
    output logic             stall_FD,
    output logic             stall_XM,
    output logic             flush_D,
    output logic             flush_X,
    output logic             flush_W,
    output logic [1:0]       fwdA_X,
    output logic [1:0]       fwdB_X,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    logic       freeze;
    logic       x_writes;
    logic       m_writes;
    logic       load_use;
    logic [1:0] fwd_a_nxt;
    logic [1:0] fwd_b_nxt;
    logic       wait_next;

    // Freeze is evaluated in both states so the very first stalled cycle
    // (still in RUN) already holds the pipe.
    assign freeze   = mem_req_M & ~mem_ready;
    assign x_writes = RegWrite_X & (dst_X != 5'd0);
    assign m_writes = RegWrite_M & (dst_M != 5'd0);
    assign load_use = MemRead_X & x_writes &
                      ((use_rs_D & (rs_D == dst_X)) | (use_rt_D & (rt_D == dst_X)));

    // Next cycle is a memory-wait cycle: entering from RUN, or still waiting.
    assign wait_next = (state == RUN) ? freeze : ~mem_ready;

    always_comb begin
        stall_FD = 1'b0;
        stall_XM = 1'b0;
        flush_D  = 1'b0;
        flush_X  = 1'b0;
        flush_W  = 1'b0;
        if (freeze) begin
            stall_FD = 1'b1;
            stall_XM = 1'b1;
            flush_W  = 1'b1;
        end else if (BeqValid_X) begin
            flush_D = 1'b1;
            flush_X = 1'b1;
        end else if (load_use) begin
            stall_FD = 1'b1;
            flush_X  = 1'b1;
        end else if (Jump_D) begin
            flush_D = 1'b1;
        end
    end

    // The instruction now in Execute will sit in Memory next cycle (01),
    // the one in Memory will sit in Writeback (10); the nearer producer wins.
    always_comb begin
        fwd_a_nxt = 2'b00;
        fwd_b_nxt = 2'b00;
        if (x_writes && rs_D == dst_X)      fwd_a_nxt = 2'b01;
        else if (m_writes && rs_D == dst_M) fwd_a_nxt = 2'b10;
        if (x_writes && rt_D == dst_X)      fwd_b_nxt = 2'b01;
        else if (m_writes && rt_D == dst_M) fwd_b_nxt = 2'b10;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwdA_X <= 2'b00;
            fwdB_X <= 2'b00;
        end else if (stall_XM) begin
            fwdA_X <= fwdA_X;
            fwdB_X <= fwdB_X;
        end else if (flush_X) begin
            fwdA_X <= 2'b00;
            fwdB_X <= 2'b00;
        end else begin
            fwdA_X <= fwd_a_nxt;
            fwdB_X <= fwd_b_nxt;
        end
    end

    // Wait FSM: wait_cnt equals the number of consecutive memory-wait
    // cycles so far; it saturates at TIMEOUT so it can never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (wait_next) begin
                state <= MEM_WAIT;
                if (wait_cnt != WAIT_W'(TIMEOUT))
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                if (wait_cnt + WAIT_W'(1) >= WAIT_W'(TIMEOUT))
                    mem_timeout <= 1'b1;
            end else begin
                state    <= RUN;
                wait_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (stall_FD && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int TO = 10;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs_D, rt_D, dst_X, dst_M;
    logic          use_rs_D, use_rt_D, RegWrite_X, RegWrite_M, MemRead_X;
    logic          mem_req_M, mem_ready, BeqValid_X, Jump_D;
    logic          stall_FD, stall_XM, flush_D, flush_X, flush_W;
    logic [1:0]    fwdA_X, fwdB_X;
    logic          mem_timeout;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
        .dst_X(dst_X), .dst_M(dst_M), .RegWrite_X(RegWrite_X), .RegWrite_M(RegWrite_M),
        .MemRead_X(MemRead_X), .mem_req_M(mem_req_M), .mem_ready(mem_ready),
        .BeqValid_X(BeqValid_X), .Jump_D(Jump_D),
        .stall_FD(stall_FD), .stall_XM(stall_XM), .flush_D(flush_D), .flush_X(flush_X),
        .flush_W(flush_W), .fwdA_X(fwdA_X), .fwdB_X(fwdB_X),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Order: {stall_FD, stall_XM, flush_D, flush_X, flush_W}
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chkv(tag, 32'({stall_FD, stall_XM, flush_D, flush_X, flush_W}), 32'(exp));
    endtask

    task automatic clr();
        rs_D = 5'd0; rt_D = 5'd0; dst_X = 5'd0; dst_M = 5'd0;
        use_rs_D = 1'b0; use_rt_D = 1'b0; RegWrite_X = 1'b0; RegWrite_M = 1'b0;
        MemRead_X = 1'b0; mem_req_M = 1'b0; mem_ready = 1'b1;
        BeqValid_X = 1'b0; Jump_D = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst = 1'b0;
        #3;
        chkv("rst_fwdA", 32'(fwdA_X), 32'd0);
        chkv("rst_fwdB", 32'(fwdB_X), 32'd0);
        chkv("rst_timeout", 32'(mem_timeout), 32'd0);
        chkv("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk_ctl("rst_ctl", 5'b00000);
        tick();
        rst = 1'b1;
        tick();

        // Load-use on rs, then the load reaches Memory -> forward from W
        dst_X = 5'd5; MemRead_X = 1'b1; RegWrite_X = 1'b1; rs_D = 5'd5; use_rs_D = 1'b1;
        #1;
        chk_ctl("loaduse_ctl", 5'b10010);
        tick();
        chkv("loaduse_fwdA_bubble", 32'(fwdA_X), 32'd0);
        chkv("loaduse_stall_cnt", 32'(stall_cnt), 32'd1);
        dst_X = 5'd0; MemRead_X = 1'b0; RegWrite_X = 1'b0;
        dst_M = 5'd5; RegWrite_M = 1'b1; mem_req_M = 1'b1; mem_ready = 1'b1;
        #1;
        chk_ctl("loaduse_next_ctl", 5'b00000);
        tick();
        chkv("loaduse_fwdA_W", 32'(fwdA_X), 32'd2);

        // X match beats M match on rt
        clr();
        dst_X = 5'd3; RegWrite_X = 1'b1; rt_D = 5'd3; use_rt_D = 1'b1;
        dst_M = 5'd3; RegWrite_M = 1'b1;
        tick();
        chkv("fwdB_X_prio", 32'(fwdB_X), 32'd1);
        chkv("fwdA_none", 32'(fwdA_X), 32'd0);
        // M only
        dst_X = 5'd4;
        tick();
        chkv("fwdB_M_only", 32'(fwdB_X), 32'd2);
        // Register $0 never forwarded
        dst_X = 5'd0; dst_M = 5'd0; rt_D = 5'd0; rs_D = 5'd0;
        tick();
        chkv("fwdB_r0", 32'(fwdB_X), 32'd0);
        chkv("fwdA_r0", 32'(fwdA_X), 32'd0);

        // Branch beats load-use and jump
        clr();
        dst_X = 5'd7; MemRead_X = 1'b1; RegWrite_X = 1'b1; rt_D = 5'd7; use_rt_D = 1'b1;
        rs_D = 5'd7; BeqValid_X = 1'b1; Jump_D = 1'b1;
        #1;
        chk_ctl("branch_prio_ctl", 5'b00110);
        tick();
        chkv("branch_fwdA_flushed", 32'(fwdA_X), 32'd0);
        chkv("branch_stall_cnt", 32'(stall_cnt), 32'd1);

        // Jump alone
        clr();
        Jump_D = 1'b1;
        #1;
        chk_ctl("jump_ctl", 5'b00100);

        // Load-use beats jump
        dst_X = 5'd9; MemRead_X = 1'b1; RegWrite_X = 1'b1; rt_D = 5'd9; use_rt_D = 1'b1;
        #1;
        chk_ctl("loaduse_over_jump", 5'b10010);
        tick();
        chkv("loaduse_jump_stall_cnt", 32'(stall_cnt), 32'd2);

        // Matching source that is not read: no stall
        clr();
        dst_X = 5'd6; MemRead_X = 1'b1; RegWrite_X = 1'b1; rs_D = 5'd6; use_rs_D = 1'b0;
        #1;
        chk_ctl("unused_src_ctl", 5'b00000);
        // Load to $0: no stall
        dst_X = 5'd0; rs_D = 5'd0; use_rs_D = 1'b1;
        #1;
        chk_ctl("load_r0_ctl", 5'b00000);

        // Set a forward value that must hold through the freeze
        clr();
        dst_X = 5'd3; RegWrite_X = 1'b1; rs_D = 5'd3;
        tick();
        chkv("pre_freeze_fwdA", 32'(fwdA_X), 32'd1);

        // Three-cycle memory wait, branch present but freeze wins
        clr();
        mem_req_M = 1'b1; mem_ready = 1'b0; BeqValid_X = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_ctl("freeze_ctl", 5'b11001);
            tick();
        end
        chkv("freeze_fwdA_hold", 32'(fwdA_X), 32'd1);
        mem_ready = 1'b1; BeqValid_X = 1'b0;
        #1;
        chk_ctl("freeze_release_ctl", 5'b00000);
        tick();
        chkv("freeze_timeout", 32'(mem_timeout), 32'd0);
        chkv("freeze_stall_cnt", 32'(stall_cnt), 32'd5);

        // Nine waits after a cleared counter: just below the limit
        mem_ready = 1'b0;
        repeat (TO - 1) tick();
        chkv("wait_below_limit", 32'(mem_timeout), 32'd0);
        chkv("stall_cnt_14", 32'(stall_cnt), 32'd14);
        mem_ready = 1'b1;
        tick();
        chkv("wait_cleared_timeout", 32'(mem_timeout), 32'd0);

        // Exactly TIMEOUT waits: error sets and sticks
        mem_ready = 1'b0;
        repeat (TO - 1) tick();
        chkv("wait_limit_minus1", 32'(mem_timeout), 32'd0);
        tick();
        chkv("wait_limit", 32'(mem_timeout), 32'd1);
        chkv("stall_cnt_saturated", 32'(stall_cnt), 32'd15);
        mem_ready = 1'b1;
        repeat (2) tick();
        chkv("timeout_sticky", 32'(mem_timeout), 32'd1);
        chkv("stall_cnt_still_sat", 32'(stall_cnt), 32'd15);

        // Reset asserted mid-wait, away from a clock edge
        mem_ready = 1'b0;
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        chkv("midwait_rst_timeout", 32'(mem_timeout), 32'd0);
        chkv("midwait_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chkv("midwait_rst_fwdA", 32'(fwdA_X), 32'd0);
        chk_ctl("midwait_rst_ctl_follows", 5'b11001);
        tick();
        rst = 1'b1;
        repeat (TO - 1) tick();
        chkv("post_rst_below_limit", 32'(mem_timeout), 32'd0);
        tick();
        chkv("post_rst_limit", 32'(mem_timeout), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
